// File: rtl/mvm_acc_pkg.sv
// Shared constants, opcodes and FSM state type for the MVM accelerator engine.
// Imported by the engine top, its MAC datapath and its bus interface.
package mvm_acc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ELEM_W_DEF = 4;
    localparam int DIM_DEF    = 4;
    localparam int IDX_W      = 2;

    localparam logic [4:0] OP_MVM = 5'b11111;
    localparam logic [4:0] OP_DIC = 5'b11110;

    localparam int MODE_BIT = 10;
    localparam int IDX_LSB  = 8;

    localparam logic [2:0] MEM_SRC_ACC = 3'b110;

    typedef enum logic {
        IDLE,
        COMPUTE
    } state_t;

    function automatic logic [IDX_W-1:0] instr_idx(input logic [15:0] instr);
        return instr[IDX_LSB +: IDX_W];
    endfunction

endpackage

// File: rtl/mvm_acc_engine_if.sv
// Core-to-accelerator command and write-back signals for the MVM engine.
// The core side is the master; the engine is the slave.
interface mvm_acc_engine_if
    import mvm_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              acc_req;
    logic              dic_req;
    logic [15:0]       instr;
    logic [DATA_W-1:0] acc_data;
    logic [DATA_W-1:0] dic_data;
    logic              busy;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output acc_req, dic_req, instr, acc_data,
        input  dic_data, busy, stall, done, err
    );

    modport slave (
        input  acc_req, dic_req, instr, acc_data,
        output dic_data, busy, stall, done, err
    );
endinterface

// File: rtl/mvm_acc_mac.sv
// Signed element multiply with sign extension into a wrapping accumulator.
// clear wins over en so a row boundary and a new compute both restart from zero.
module mvm_acc_mac
    import mvm_acc_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int ACC_W  = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic signed [ELEM_W-1:0] w,
    input  logic signed [ELEM_W-1:0] v,
    output logic        [ACC_W-1:0]  sum
);
    logic        [ACC_W-1:0]    acc;
    logic signed [2*ELEM_W-1:0] prod;

    assign prod = w * v;
    assign sum  = acc + {{(ACC_W - 2*ELEM_W){prod[2*ELEM_W-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end
endmodule

// File: rtl/mvm_acc_engine.sv
// Accelerator responder: loads weight rows, runs a DIM x DIM signed
// matrix-vector multiply one MAC per cycle, and returns rows over DIC.
module mvm_acc_engine
    import mvm_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int DIM    = DIM_DEF
) (
    input logic             clk,
    input logic             rst_n,
    mvm_acc_engine_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    state_t state, next_state;

    logic [IDX_W-1:0]         row, col;
    logic [DATA_W-1:0]        w_row [DIM];
    logic [DATA_W-1:0]        res   [DIM];
    logic [DATA_W-1:0]        vec;
    logic [DATA_W-1:0]        mac_sum;
    logic signed [ELEM_W-1:0] w_el, v_el;
    logic                     computing, idle_cmd, start, load, row_end;
    logic                     done_q, err_q;
    logic                     unused_instr;

    assign computing = (state == COMPUTE);
    assign idle_cmd  = bus.acc_req && !computing;
    assign start     = idle_cmd && bus.instr[MODE_BIT];
    assign load      = idle_cmd && !bus.instr[MODE_BIT];
    assign row_end   = computing && (col == LAST);

    assign w_el = w_row[row][int'(col)*ELEM_W +: ELEM_W];
    assign v_el = vec[int'(col)*ELEM_W +: ELEM_W];

    assign unused_instr = ^{bus.instr[15:11], bus.instr[7:0]};

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = COMPUTE;
            COMPUTE: if (row == LAST && col == LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Commands arriving mid-compute never touch weights or the sequencer; they only flag err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                w_row[i] <= '0;
                res[i]   <= '0;
            end
            vec    <= '0;
            row    <= '0;
            col    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (load) w_row[instr_idx(bus.instr)] <= bus.acc_data;
            if (start) begin
                vec    <= bus.acc_data;
                row    <= '0;
                col    <= '0;
                done_q <= 1'b0;
            end
            if (bus.acc_req && computing) err_q <= 1'b1;
            if (computing) begin
                if (col == LAST) begin
                    res[row] <= mac_sum;
                    col      <= '0;
                    row      <= row + 1'b1;
                    if (row == LAST) done_q <= 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    mvm_acc_mac #(
        .ELEM_W (ELEM_W),
        .ACC_W  (DATA_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (computing),
        .clear (start || row_end),
        .w     (w_el),
        .v     (v_el),
        .sum   (mac_sum)
    );

    assign bus.busy     = computing;
    assign bus.stall    = bus.dic_req && computing;
    assign bus.dic_data = bus.dic_req ? res[instr_idx(bus.instr)] : '0;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
